// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

   // Fetch sequencer states: request, wait for data, hold instruction, drop late response
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] WORD_ALIGN_MASK      = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle
interface fetch_unit_if;

   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemReady;
   logic        IMemRValid;
   logic [31:0] IMemRData;

   // Fetch side drives the request, memory side drives acceptance and read data
   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemReady,
      input  IMemRValid,
      input  IMemRData
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemReady,
      output IMemRValid,
      output IMemRData
   );

endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter register with redirect mux and link adders
module fetch_pc
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_consume,
   input  logic        i_PCSrc,
   input  logic [31:0] i_PCTarget,
   output logic [31:0] o_PC,
   output logic [31:0] o_PCPlus4,
   output logic [31:0] o_PCPlus8
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_plus8;
   logic [31:0] w_next_pc;

   // Sequential advance or word-aligned redirect; both wrap modulo 2^32
   always_comb begin
      w_pc_plus4 = r_pc + 32'd4;
      w_pc_plus8 = r_pc + 32'd8;
      w_next_pc  = i_PCSrc ? (i_PCTarget & WORD_ALIGN_MASK) : w_pc_plus4;
   end

   // PC only moves when the held instruction is consumed downstream
   always_ff @(posedge clk) begin
      if (reset)
         r_pc <= RESET_VECTOR & WORD_ALIGN_MASK;
      else if (i_consume)
         r_pc <= w_next_pc;
   end

   assign o_PC      = r_pc;
   assign o_PCPlus4 = w_pc_plus4;
   assign o_PCPlus8 = w_pc_plus8;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage with timeout detection
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int          TIMEOUT      = 16,
   parameter int          CNT_W        = 5
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master imem,
   input  logic         i_Stall,
   input  logic         i_PCSrc,
   input  logic [31:0]  i_PCTarget,
   output logic [31:0]  o_Instr,
   output logic         o_InstrValid,
   output logic [31:0]  o_PC,
   output logic [31:0]  o_PCPlus4,
   output logic [31:0]  o_PCPlus8,
   output logic         o_FetchErr
);

   localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

   fetch_state_t     r_state;
   fetch_state_t     w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [31:0]      r_instr;
   logic             r_err;
   logic             w_req;
   logic             w_accept;
   logic             w_consume;
   logic             w_timeout;
   logic [31:0]      w_pc;

   // Handshake qualifiers; the counter saturates so it can never wrap back below TIMEOUT
   always_comb begin
      w_accept  = (r_state == S_REQ) && imem.IMemReady && !reset;
      w_consume = (r_state == S_HOLD) && !i_Stall;
      w_cnt_inc = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
      w_timeout = (r_state == S_WAIT) && !imem.IMemRValid && (w_cnt_inc >= L_TIMEOUT);
   end

   // Next-state and request decode; a response arriving on the last wait cycle still wins
   always_comb begin
      w_next_state = r_state;
      w_req        = 1'b0;
      case (r_state)
         S_REQ: begin
            w_req = !reset;
            if (imem.IMemReady)
               w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (imem.IMemRValid)
               w_next_state = S_HOLD;
            else if (w_timeout)
               w_next_state = S_DROP;
         end
         S_HOLD: begin
            if (!i_Stall)
               w_next_state = S_REQ;
         end
         S_DROP: begin
            if (imem.IMemRValid)
               w_next_state = S_REQ;
         end
         default: w_next_state = S_REQ;
      endcase
   end

   // State register; reset returns to requesting so any in-flight response is never sampled
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_REQ;
      else
         r_state <= w_next_state;
   end

   // Wait-cycle counter, restarted on every accepted request
   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (w_accept)
         r_cnt <= '0;
      else if (r_state == S_WAIT)
         r_cnt <= w_cnt_inc;
   end

   // Instruction register captures read data only for the outstanding request
   always_ff @(posedge clk) begin
      if (reset)
         r_instr <= 32'd0;
      else if ((r_state == S_WAIT) && imem.IMemRValid)
         r_instr <= imem.IMemRData;
   end

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)
         r_err <= 1'b0;
      else if (w_timeout)
         r_err <= 1'b1;
   end

   fetch_pc #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_fetch_pc (
      .clk        (clk),
      .reset      (reset),
      .i_consume  (w_consume),
      .i_PCSrc    (i_PCSrc),
      .i_PCTarget (i_PCTarget),
      .o_PC       (w_pc),
      .o_PCPlus4  (o_PCPlus4),
      .o_PCPlus8  (o_PCPlus8)
   );

   assign imem.IMemReq  = w_req;
   assign imem.IMemAddr = w_pc;
   assign o_Instr       = r_instr;
   assign o_InstrValid  = (r_state == S_HOLD);
   assign o_PC          = w_pc;
   assign o_FetchErr    = r_err;

endmodule
